// File: rtl/btb_update_ctrl.sv
// BTB write-side controller: buffers resolved-branch updates in a small FIFO and
// drains them to the single BTB write port; runs a full-array invalidate walk on request.
module btb_update_ctrl #(
  parameter int IDX_W      = 3,
  parameter int TAG_W      = 3,
  parameter int TGT_W      = 6,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     memory_stall,
  input  logic                     upd_valid,
  input  logic [IDX_W-1:0]         upd_idx,
  input  logic [TAG_W-1:0]         upd_tag,
  input  logic [TGT_W-1:0]         upd_tgt,
  output logic                     upd_ready,
  input  logic                     inv_req,
  output logic                     wr_en,
  output logic [IDX_W-1:0]         wr_idx,
  output logic [TAG_W+TGT_W:0]     wr_data,
  output logic                     busy,
  output logic                     inv_done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = IDX_W + TAG_W + TGT_W;
  localparam logic [IDX_W-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {S_IDLE, S_INV, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       cnt_q, cnt_d;
  logic [PTR_W:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ENT_W-1:0]       mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0]       mem_d [FIFO_DEPTH];
  logic                   wr_en_q, wr_en_d;
  logic [IDX_W-1:0]       wr_idx_q, wr_idx_d;
  logic [TAG_W+TGT_W:0]   wr_data_q, wr_data_d;
  logic                   busy_q, busy_d;
  logic                   inv_done_q, inv_done_d;

  logic                   full, empty, push, flush;
  logic [ENT_W-1:0]       head;

  // Full/empty come from registered pointers only, so upd_ready never depends on a pop.
  assign full  = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                 (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
  assign empty = (wptr_q == rptr_q);
  assign push  = upd_valid && !full;
  assign head  = mem_q[rptr_q[PTR_W-1:0]];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    mem_d      = mem_q;
    wr_en_d    = 1'b0;
    wr_idx_d   = '0;
    wr_data_d  = '0;
    flush      = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (inv_req) begin
          flush   = 1'b1;
          cnt_d   = '0;
          state_d = S_INV;
        end else begin
          state_d = S_IDLE;
          if (state_q == S_IDLE && !empty && !memory_stall) begin
            wr_en_d   = 1'b1;
            wr_idx_d  = head[ENT_W-1 -: IDX_W];
            wr_data_d = {1'b1, head[TAG_W+TGT_W-1:0]};
            rptr_d    = rptr_q + 1'b1;
          end
        end
      end
      S_INV: begin
        if (inv_req) begin
          flush = 1'b1;
          cnt_d = '0;
        end else if (!memory_stall) begin
          wr_en_d  = 1'b1;
          wr_idx_d = cnt_q;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == LAST_IDX) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Flush discards entries present at this edge; a same-cycle push still lands.
    if (flush) rptr_d = wptr_q;
    if (push) begin
      mem_d[wptr_q[PTR_W-1:0]] = {upd_idx, upd_tag, upd_tgt};
      wptr_d = wptr_q + 1'b1;
    end

    busy_d     = (state_d != S_IDLE) && !(state_q == S_DONE && state_d == S_IDLE);
    inv_done_d = (state_q == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_en_q    <= 1'b0;
      wr_idx_q   <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      inv_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_en_q    <= wr_en_d;
      wr_idx_q   <= wr_idx_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      inv_done_q <= inv_done_d;
    end
  end

  assign upd_ready = !full;
  assign wr_en     = wr_en_q;
  assign wr_idx    = wr_idx_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign inv_done  = inv_done_q;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed self-checking bench for btb_update_ctrl: FIFO drain, invalidate walk,
// stall/restart of the walk and asynchronous reset mid-walk.
module tb_btb_update_ctrl;

  localparam int IDX_W = 3;
  localparam int TAG_W = 3;
  localparam int TGT_W = 6;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 memory_stall;
  logic                 upd_valid;
  logic [IDX_W-1:0]     upd_idx;
  logic [TAG_W-1:0]     upd_tag;
  logic [TGT_W-1:0]     upd_tgt;
  logic                 upd_ready;
  logic                 inv_req;
  logic                 wr_en;
  logic [IDX_W-1:0]     wr_idx;
  logic [TAG_W+TGT_W:0] wr_data;
  logic                 busy;
  logic                 inv_done;

  int n_cmp  = 0;
  int n_fail = 0;

  btb_update_ctrl #(.IDX_W(IDX_W), .TAG_W(TAG_W), .TGT_W(TGT_W), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .memory_stall(memory_stall),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_tag(upd_tag), .upd_tgt(upd_tgt),
    .upd_ready(upd_ready), .inv_req(inv_req),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .busy(busy), .inv_done(inv_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_upd(input logic v, input logic [2:0] i, input logic [2:0] t,
                         input logic [5:0] g);
    upd_valid = v; upd_idx = i; upd_tag = t; upd_tgt = g;
  endtask

  task automatic test_reset();
    rst = 1'b1; memory_stall = 1'b0; inv_req = 1'b0; set_upd(1'b0, 3'd0, 3'd0, 6'd0);
    step(); step();
    n_cmp++;
    if ({wr_en, wr_idx, wr_data, busy, inv_done, upd_ready} !== {1'b0, 3'd0, 10'd0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_state: got en=%b idx=%0d data=%b busy=%b done=%b rdy=%b, want 0/0/0/0/0/1",
               wr_en, wr_idx, wr_data, busy, inv_done, upd_ready);
    end
    #3 rst = 1'b0;
    step();
  endtask

  task automatic test_inv_walk();
    inv_req = 1'b1; step(); inv_req = 1'b0;
    n_cmp++;
    if ({busy, wr_en} !== 2'b10) begin
      n_fail++; $display("FAIL walk_start: got busy=%b en=%b, want busy=1 en=0", busy, wr_en);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      n_cmp++;
      if ({wr_en, wr_idx, wr_data, busy, inv_done} !== {1'b1, 3'(i), 10'd0, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL walk_write%0d: got en=%b idx=%0d data=%b busy=%b done=%b, want en=1 idx=%0d data=0 busy=1 done=0",
                 i, wr_en, wr_idx, wr_data, busy, inv_done, i);
      end
    end
    step();
    n_cmp++;
    if ({inv_done, busy, wr_en} !== 3'b100) begin
      n_fail++; $display("FAIL walk_done: got done=%b busy=%b en=%b, want 1/0/0", inv_done, busy, wr_en);
    end
    step();
    n_cmp++;
    if ({inv_done, busy, wr_en} !== 3'b000) begin
      n_fail++; $display("FAIL walk_after: got done=%b busy=%b en=%b, want 0/0/0", inv_done, busy, wr_en);
    end
  endtask

  task automatic test_back_to_back();
    memory_stall = 1'b1;
    set_upd(1'b1, 3'd1, 3'd3, 6'h05); step();
    set_upd(1'b1, 3'd2, 3'd4, 6'h2a); step();
    set_upd(1'b1, 3'd3, 3'd7, 6'h3f);
    n_cmp++;
    if ({upd_ready, wr_en} !== 2'b00) begin
      n_fail++; $display("FAIL b2b_full: got rdy=%b en=%b, want rdy=0 en=0", upd_ready, wr_en);
    end
    step();
    n_cmp++;
    if ({upd_ready, wr_en} !== 2'b00) begin
      n_fail++; $display("FAIL b2b_stalled: got rdy=%b en=%b, want rdy=0 en=0", upd_ready, wr_en);
    end
    memory_stall = 1'b0;
    step();
    n_cmp++;
    if ({wr_en, wr_idx, wr_data, upd_ready} !== {1'b1, 3'd1, 1'b1, 3'd3, 6'h05, 1'b1}) begin
      n_fail++; $display("FAIL b2b_A: got en=%b idx=%0d data=%b rdy=%b, want 1/1/1011000101/1",
                         wr_en, wr_idx, wr_data, upd_ready);
    end
    step();
    set_upd(1'b0, 3'd0, 3'd0, 6'd0);
    n_cmp++;
    if ({wr_en, wr_idx, wr_data} !== {1'b1, 3'd2, 1'b1, 3'd4, 6'h2a}) begin
      n_fail++; $display("FAIL b2b_B: got en=%b idx=%0d data=%b, want 1/2/1100101010", wr_en, wr_idx, wr_data);
    end
    step();
    n_cmp++;
    if ({wr_en, wr_idx, wr_data} !== {1'b1, 3'd3, 1'b1, 3'd7, 6'h3f}) begin
      n_fail++; $display("FAIL b2b_C: got en=%b idx=%0d data=%b, want 1/3/1111111111", wr_en, wr_idx, wr_data);
    end
    step();
    n_cmp++;
    if (wr_en !== 1'b0) begin
      n_fail++; $display("FAIL b2b_drained: got en=%b, want 0", wr_en);
    end
  endtask

  task automatic test_inv_flush();
    int nwr = 0;
    int bad = 0;
    bit seen_done = 0;
    memory_stall = 1'b1;
    set_upd(1'b1, 3'd4, 3'd1, 6'h01); step();
    set_upd(1'b1, 3'd6, 3'd2, 6'h02); step();
    set_upd(1'b0, 3'd0, 3'd0, 6'd0);
    memory_stall = 1'b0; inv_req = 1'b1; step(); inv_req = 1'b0;
    n_cmp++;
    if ({busy, upd_ready, wr_en} !== 3'b110) begin
      n_fail++; $display("FAIL flush_start: got busy=%b rdy=%b en=%b, want 1/1/0", busy, upd_ready, wr_en);
    end
    set_upd(1'b1, 3'd5, 3'd6, 6'h1c); step(); set_upd(1'b0, 3'd0, 3'd0, 6'd0);
    for (int c = 0; c < 20 && !seen_done; c++) begin
      if (wr_en) begin
        if (wr_data !== 10'd0 || wr_idx !== 3'(nwr)) bad++;
        nwr++;
      end
      if (inv_done) seen_done = 1;
      else step();
    end
    n_cmp++;
    if (!seen_done || nwr != 8 || bad != 0) begin
      n_fail++; $display("FAIL flush_walk: got done=%0d writes=%0d bad=%0d, want done=1 writes=8 bad=0",
                         seen_done, nwr, bad);
    end
    step();
    n_cmp++;
    if ({wr_en, wr_idx, wr_data} !== {1'b1, 3'd5, 1'b1, 3'd6, 6'h1c}) begin
      n_fail++; $display("FAIL flush_D: got en=%b idx=%0d data=%b, want 1/5/1110011100", wr_en, wr_idx, wr_data);
    end
    step();
    n_cmp++;
    if (wr_en !== 1'b0) begin
      n_fail++; $display("FAIL flush_stale: got en=%b idx=%0d, want en=0 (stale entries dropped)", wr_en, wr_idx);
    end
  endtask

  task automatic test_inv_stall();
    inv_req = 1'b1; step(); inv_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        memory_stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
          step();
          n_cmp++;
          if ({wr_en, busy} !== 2'b01) begin
            n_fail++; $display("FAIL stall_hold%0d: got en=%b busy=%b, want en=0 busy=1", s, wr_en, busy);
          end
        end
        memory_stall = 1'b0;
      end
      step();
      n_cmp++;
      if ({wr_en, wr_idx, wr_data} !== {1'b1, 3'(i), 10'd0}) begin
        n_fail++; $display("FAIL stall_write%0d: got en=%b idx=%0d data=%b, want en=1 idx=%0d data=0",
                           i, wr_en, wr_idx, wr_data, i);
      end
    end
    step();
    n_cmp++;
    if ({inv_done, busy} !== 2'b10) begin
      n_fail++; $display("FAIL stall_done: got done=%b busy=%b, want 1/0", inv_done, busy);
    end
    step();
  endtask

  task automatic test_inv_restart();
    inv_req = 1'b1; step(); inv_req = 1'b0;
    for (int i = 0; i < 6; i++) step();
    inv_req = 1'b1; step(); inv_req = 1'b0;
    n_cmp++;
    if ({wr_en, busy, inv_done} !== 3'b010) begin
      n_fail++; $display("FAIL restart_edge: got en=%b busy=%b done=%b, want 0/1/0", wr_en, busy, inv_done);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      n_cmp++;
      if ({wr_en, wr_idx, inv_done} !== {1'b1, 3'(i), 1'b0}) begin
        n_fail++; $display("FAIL restart_write%0d: got en=%b idx=%0d done=%b, want en=1 idx=%0d done=0",
                           i, wr_en, wr_idx, inv_done, i);
      end
    end
    step();
    n_cmp++;
    if (inv_done !== 1'b1) begin
      n_fail++; $display("FAIL restart_done: got done=%b, want 1", inv_done);
    end
    step();
  endtask

  task automatic test_reset_mid();
    inv_req = 1'b1; step(); inv_req = 1'b0;
    set_upd(1'b1, 3'd7, 3'd7, 6'h3f); step(); set_upd(1'b0, 3'd0, 3'd0, 6'd0);
    step(); step();
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({wr_en, wr_idx, wr_data, busy, inv_done, upd_ready} !== {1'b0, 3'd0, 10'd0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL reset_mid: got en=%b idx=%0d data=%b busy=%b done=%b rdy=%b, want 0/0/0/0/0/1",
                         wr_en, wr_idx, wr_data, busy, inv_done, upd_ready);
    end
    rst = 1'b0;
    step(); step();
    n_cmp++;
    if ({wr_en, busy} !== 2'b00) begin
      n_fail++; $display("FAIL reset_empty: got en=%b busy=%b, want 0/0", wr_en, busy);
    end
    set_upd(1'b1, 3'd5, 3'd2, 6'h11); step(); set_upd(1'b0, 3'd0, 3'd0, 6'd0);
    n_cmp++;
    if (wr_en !== 1'b0) begin
      n_fail++; $display("FAIL reset_push_early: got en=%b, want 0", wr_en);
    end
    step();
    n_cmp++;
    if ({wr_en, wr_idx, wr_data} !== {1'b1, 3'd5, 10'b1_010_010001}) begin
      n_fail++; $display("FAIL reset_push: got en=%b idx=%0d data=%b, want 1/5/1010010001", wr_en, wr_idx, wr_data);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_inv_walk();
    test_back_to_back();
    test_inv_flush();
    test_inv_stall();
    test_inv_restart();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule
